// File: rtl/b_bop_seq.sv
// b_bop_seq: sequencer for a ternary bitwise-op (bop) unit.
// Reads two sources from a 2-port register file, reads rd as the third operand,
// evaluates through an external combinational bop unit, then writes back.
module b_bop_seq #(
   parameter bit          ZERO_X0       = 1'b1,
   // Value op_count takes on reset.
   parameter logic [15:0] OP_COUNT_INIT = 16'h0000
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_rd_addr,
   input  logic [4:0]  req_rs1_addr,
   input  logic [4:0]  req_rs2_addr,
   input  logic [7:0]  req_lut,
   output logic [4:0]  rf_addr_a,
   output logic [4:0]  rf_addr_b,
   input  logic [31:0] rf_rdata_a,
   input  logic [31:0] rf_rdata_b,
   output logic [31:0] bop_rd,
   output logic [31:0] bop_rs1,
   output logic [31:0] bop_rs2,
   output logic [7:0]  bop_lut,
   input  logic [31:0] bop_result,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {StIdle, StRdd, StExec, StWb} state_e;

   state_e      state_q, state_d;
   logic [31:0] rs1_q, rs2_q, rd_op_q, wb_data_q;
   logic [4:0]  rd_addr_q;
   logic [7:0]  lut_q;
   logic [15:0] op_count_q;

   logic cap_req, cap_rd, cap_res, count_inc;
   logic rs1_zero, rs2_zero, rd_zero;

   // Address 0 operands are forced to zero when x0 is hardwired.
   assign rs1_zero = ZERO_X0 && (req_rs1_addr == 5'd0);
   assign rs2_zero = ZERO_X0 && (req_rs2_addr == 5'd0);
   assign rd_zero  = ZERO_X0 && (rd_addr_q == 5'd0);

   // State register.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode, handshakes and register-file addressing.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      wb_valid  = 1'b0;
      rf_addr_a = req_rs1_addr;
      rf_addr_b = req_rs2_addr;
      cap_req   = 1'b0;
      cap_rd    = 1'b0;
      cap_res   = 1'b0;
      count_inc = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cap_req = 1'b1;
               state_d = StRdd;
            end
         end
         StRdd: begin
            rf_addr_a = rd_addr_q;
            rf_addr_b = rd_addr_q;
            cap_rd    = 1'b1;
            state_d   = StExec;
         end
         StExec: begin
            cap_res = 1'b1;
            // A result destined for x0 is discarded without a write-back.
            state_d = rd_zero ? StIdle : StWb;
         end
         StWb: begin
            wb_valid = 1'b1;
            if (wb_ready) begin
               count_inc = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Operand, LUT and result capture; one copy per operand so aliases agree.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         rs1_q     <= 32'h0;
         rs2_q     <= 32'h0;
         rd_op_q   <= 32'h0;
         rd_addr_q <= 5'd0;
         lut_q     <= 8'h0;
         wb_data_q <= 32'h0;
      end else begin
         if (cap_req) begin
            rs1_q     <= rs1_zero ? 32'h0 : rf_rdata_a;
            rs2_q     <= rs2_zero ? 32'h0 : rf_rdata_b;
            rd_addr_q <= req_rd_addr;
            lut_q     <= req_lut;
         end
         if (cap_rd) begin
            rd_op_q <= rd_zero ? 32'h0 : rf_rdata_a;
         end
         if (cap_res) begin
            wb_data_q <= bop_result;
         end
      end
   end

   // Completed write-back counter, saturating at all-ones.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         op_count_q <= OP_COUNT_INIT;
      end else if (count_inc && (op_count_q != 16'hFFFF)) begin
         op_count_q <= op_count_q + 16'd1;
      end
   end

   assign bop_rd   = rd_op_q;
   assign bop_rs1  = rs1_q;
   assign bop_rs2  = rs2_q;
   assign bop_lut  = lut_q;
   assign wb_addr  = rd_addr_q;
   assign wb_data  = wb_data_q;
   assign busy     = (state_q != StIdle);
   assign op_count = op_count_q;

endmodule
